// File: rtl/liteeth_rst_seq_pkg.sv
// Shared types and helpers for the LiteEth PHY/MAC reset sequencer.
package liteeth_rst_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    PHY_RST,
    SETTLE,
    RELEASE,
    DONE
  } state_t;

  localparam int N_DOMAINS_MIN = 1;
  localparam int N_DOMAINS_MAX = 8;
  localparam int CYCLES_MIN    = 1;

  // Width that holds the largest phase length without wrapping.
  function automatic int cnt_width(input int a, input int s, input int g);
    int m;
    m = a;
    if (s > m) m = s;
    if (g > m) m = g;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/liteeth_rst_timer.sv
// Loadable saturating down-counter; expired pulses once per load when the count is spent.
module liteeth_rst_timer #(
  parameter int W = 4
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] cnt;
  logic         running;

  assign expired = running && (cnt == '0);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (load) begin
      cnt     <= value;
      running <= 1'b1;
    end else if (expired) begin
      running <= 1'b0;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/liteeth_rst_seq.sv
// PHY reset pulse, settle wait and staggered per-domain preset release.
//   state     | meaning
//   WAIT_LOCK | PLL not locked, everything held in reset
//   PHY_RST   | phy_rst_n driven low
//   SETTLE    | PHY released, domains still preset
//   RELEASE   | domain presets dropping one per stagger interval
//   DONE      | all domains released, ready high
module liteeth_rst_seq
  import liteeth_rst_seq_pkg::*;
#(
  parameter int ASSERT_CYCLES  = 256,
  parameter int SETTLE_CYCLES  = 1024,
  parameter int STAGGER_CYCLES = 16,
  parameter int N_DOMAINS      = 3
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 pll_locked,
  input  logic                 soft_rst_req,
  output logic                 phy_rst_n,
  output logic [N_DOMAINS-1:0] dom_pre,
  output logic                 ready
);

  localparam int CNT_W = cnt_width(ASSERT_CYCLES, SETTLE_CYCLES, STAGGER_CYCLES);
  localparam int IDX_W = $clog2(N_DOMAINS + 1);

  if (N_DOMAINS < N_DOMAINS_MIN || N_DOMAINS > N_DOMAINS_MAX ||
      ASSERT_CYCLES < CYCLES_MIN || SETTLE_CYCLES < CYCLES_MIN ||
      STAGGER_CYCLES < CYCLES_MIN) begin : g_param_check
    $error("liteeth_rst_seq: parameter out of range");
  end

  state_t               state_q, state_d;
  logic                 phy_d, ready_d;
  logic [N_DOMAINS-1:0] pre_d;
  logic [IDX_W-1:0]     idx_q, idx_d, idx_nxt;
  logic                 tmr_load, tmr_expired;
  logic [CNT_W-1:0]     tmr_value;

  liteeth_rst_timer #(.W(CNT_W)) u_timer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load      (tmr_load),
    .value     (tmr_value),
    .expired   (tmr_expired)
  );

  // PHY_RST is entered on the lock/soft edge itself, so it needs one extra edge:
  // load ASSERT_CYCLES there, and length-1 for the phases entered on a boundary.
  always_comb begin
    state_d   = state_q;
    phy_d     = phy_rst_n;
    pre_d     = dom_pre;
    ready_d   = ready;
    idx_d     = idx_q;
    idx_nxt   = idx_q + 1'b1;
    tmr_load  = 1'b0;
    tmr_value = '0;
    if (state_q != WAIT_LOCK && !pll_locked) begin
      state_d = WAIT_LOCK;
      phy_d   = 1'b0;
      pre_d   = '1;
      ready_d = 1'b0;
      idx_d   = '0;
    end else if (state_q != WAIT_LOCK && soft_rst_req) begin
      state_d   = PHY_RST;
      phy_d     = 1'b0;
      pre_d     = '1;
      ready_d   = 1'b0;
      idx_d     = '0;
      tmr_load  = 1'b1;
      tmr_value = CNT_W'(ASSERT_CYCLES);
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (pll_locked) begin
            state_d   = PHY_RST;
            tmr_load  = 1'b1;
            tmr_value = CNT_W'(ASSERT_CYCLES);
          end
        end
        PHY_RST: begin
          if (tmr_expired) begin
            state_d   = SETTLE;
            phy_d     = 1'b1;
            tmr_load  = 1'b1;
            tmr_value = CNT_W'(SETTLE_CYCLES - 1);
          end
        end
        SETTLE: begin
          if (tmr_expired) begin
            pre_d[0] = 1'b0;
            idx_d    = '0;
            if (N_DOMAINS == 1) begin
              state_d = DONE;
              ready_d = 1'b1;
            end else begin
              state_d   = RELEASE;
              tmr_load  = 1'b1;
              tmr_value = CNT_W'(STAGGER_CYCLES - 1);
            end
          end
        end
        RELEASE: begin
          if (tmr_expired) begin
            for (int i = 0; i < N_DOMAINS; i++) begin
              if (IDX_W'(i) == idx_nxt) pre_d[i] = 1'b0;
            end
            idx_d = idx_nxt;
            if (idx_nxt == IDX_W'(N_DOMAINS - 1)) begin
              state_d = DONE;
              ready_d = 1'b1;
            end else begin
              tmr_load  = 1'b1;
              tmr_value = CNT_W'(STAGGER_CYCLES - 1);
            end
          end
        end
        DONE: ;
        default: begin
          state_d = WAIT_LOCK;
          phy_d   = 1'b0;
          pre_d   = '1;
          ready_d = 1'b0;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q   <= WAIT_LOCK;
      phy_rst_n <= 1'b0;
      dom_pre   <= '1;
      ready     <= 1'b0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      phy_rst_n <= phy_d;
      dom_pre   <= pre_d;
      ready     <= ready_d;
      idx_q     <= idx_d;
    end
  end

endmodule

// File: tb/tb_liteeth_rst_seq.sv
// Directed bench for liteeth_rst_seq with short phase lengths (4/8/2), N=3 and N=1.
module tb_liteeth_rst_seq;

  localparam int A = 4;
  localparam int S = 8;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic       phy3, rdy3, phy1, rdy1;
  logic [2:0] pre3;
  logic [0:0] pre1;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;

  always #5 clk = ~clk;

  liteeth_rst_seq #(.ASSERT_CYCLES(A), .SETTLE_CYCLES(S), .STAGGER_CYCLES(G), .N_DOMAINS(3)) dut3 (
    .sys_clk(clk), .sys_rst_n(sys_rst_n), .pll_locked(pll_locked), .soft_rst_req(soft_rst_req),
    .phy_rst_n(phy3), .dom_pre(pre3), .ready(rdy3));

  liteeth_rst_seq #(.ASSERT_CYCLES(A), .SETTLE_CYCLES(S), .STAGGER_CYCLES(G), .N_DOMAINS(1)) dut1 (
    .sys_clk(clk), .sys_rst_n(sys_rst_n), .pll_locked(pll_locked), .soft_rst_req(soft_rst_req),
    .phy_rst_n(phy1), .dom_pre(pre1), .ready(rdy1));

  task automatic step();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) step();
  endtask

  // Expected outputs of the N=3 instance at edge e for a sequence started at edge t.
  function automatic logic exp_phy(input int t, input int e);
    return (e >= t + 1 + A);
  endfunction

  function automatic logic [2:0] exp_pre(input int t, input int e);
    logic [2:0] p;
    p = 3'b111;
    for (int i = 0; i < 3; i++)
      if (e >= t + 1 + A + S + i * G) p[i] = 1'b0;
    return p;
  endfunction

  function automatic logic exp_rdy(input int t, input int e);
    return (e >= t + 1 + A + S + 2 * G);
  endfunction

  task automatic test_reset();
    sys_rst_n = 1'b0;
    run_to(3);
    checks++;
    if (phy3 !== 1'b0 || pre3 !== 3'b111 || rdy3 !== 1'b0) begin
      failures++;
      $display("FAIL reset_n3: phy=%b pre=%b rdy=%b want 0 111 0", phy3, pre3, rdy3);
    end
    checks++;
    if (phy1 !== 1'b0 || pre1 !== 1'b1 || rdy1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_n1: phy=%b pre=%b rdy=%b want 0 1 0", phy1, pre1, rdy1);
    end
    sys_rst_n = 1'b1;
    run_to(5);
    soft_rst_req = 1'b1;   // sampled at edge 6 in WAIT_LOCK: must be ignored
    step();
    soft_rst_req = 1'b0;
    run_to(9);
    checks++;
    if (phy3 !== 1'b0 || pre3 !== 3'b111 || rdy3 !== 1'b0) begin
      failures++;
      $display("FAIL wait_lock_hold: phy=%b pre=%b rdy=%b want 0 111 0", phy3, pre3, rdy3);
    end
  endtask

  task automatic test_cold_start();
    pll_locked = 1'b1;     // sampled at edge 10
    for (int e = 10; e <= 30; e++) begin
      step();
      checks++;
      if (phy3 !== exp_phy(10, e) || pre3 !== exp_pre(10, e) || rdy3 !== exp_rdy(10, e)) begin
        failures++;
        $display("FAIL cold_start edge %0d: phy=%b pre=%b rdy=%b want %b %b %b",
                 e, phy3, pre3, rdy3, exp_phy(10, e), exp_pre(10, e), exp_rdy(10, e));
      end
      checks++;
      if (pre1 !== (e >= 23 ? 1'b0 : 1'b1) || rdy1 !== (e >= 23)) begin
        failures++;
        $display("FAIL single_domain edge %0d: pre=%b rdy=%b want %b %b",
                 e, pre1, rdy1, (e < 23), (e >= 23));
      end
    end
    checks++;
    if (phy3 !== 1'b1 || pre3 !== 3'b000 || rdy3 !== 1'b1) begin
      failures++;
      $display("FAIL cold_done: phy=%b pre=%b rdy=%b want 1 000 1", phy3, pre3, rdy3);
    end
  endtask

  task automatic test_lock_loss();
    pll_locked = 1'b0;     // lost at 31 in DONE
    step();
    checks++;
    if (phy3 !== 1'b0 || pre3 !== 3'b111 || rdy3 !== 1'b0) begin
      failures++;
      $display("FAIL lock_loss_done: phy=%b pre=%b rdy=%b want 0 111 0", phy3, pre3, rdy3);
    end
    run_to(34);
    pll_locked = 1'b1;     // relock at 35, SETTLE runs 40..47
    run_to(44);
    checks++;
    if (phy3 !== 1'b1 || pre3 !== 3'b111) begin
      failures++;
      $display("FAIL settle_phase: phy=%b pre=%b want 1 111", phy3, pre3);
    end
    pll_locked = 1'b0;     // lost at 45 during SETTLE
    step();
    checks++;
    if (phy3 !== 1'b0 || pre3 !== 3'b111 || rdy3 !== 1'b0) begin
      failures++;
      $display("FAIL lock_loss_settle: phy=%b pre=%b rdy=%b want 0 111 0", phy3, pre3, rdy3);
    end
    run_to(54);
    pll_locked = 1'b1;     // relock at 55
    for (int e = 55; e <= 75; e++) begin
      step();
      checks++;
      if (phy3 !== exp_phy(55, e) || pre3 !== exp_pre(55, e) || rdy3 !== exp_rdy(55, e)) begin
        failures++;
        $display("FAIL relock edge %0d: phy=%b pre=%b rdy=%b want %b %b %b",
                 e, phy3, pre3, rdy3, exp_phy(55, e), exp_pre(55, e), exp_rdy(55, e));
      end
    end
  endtask

  task automatic test_soft_reset();
    run_to(79);
    soft_rst_req = 1'b1;   // edge 80 in DONE
    step();
    soft_rst_req = 1'b0;
    checks++;
    if (phy3 !== 1'b0 || pre3 !== 3'b111 || rdy3 !== 1'b0) begin
      failures++;
      $display("FAIL soft_in_done: phy=%b pre=%b rdy=%b want 0 111 0", phy3, pre3, rdy3);
    end
    run_to(82);
    soft_rst_req = 1'b1;   // edge 83 in PHY_RST restarts the count
    for (int e = 83; e <= 105; e++) begin
      step();
      soft_rst_req = 1'b0;
      checks++;
      if (phy3 !== exp_phy(83, e) || pre3 !== exp_pre(83, e) || rdy3 !== exp_rdy(83, e)) begin
        failures++;
        $display("FAIL soft_restart edge %0d: phy=%b pre=%b rdy=%b want %b %b %b",
                 e, phy3, pre3, rdy3, exp_phy(83, e), exp_pre(83, e), exp_rdy(83, e));
      end
    end
  endtask

  task automatic test_soft_with_lock_loss();
    soft_rst_req = 1'b1;   // edge 106: lock loss wins
    pll_locked   = 1'b0;
    step();
    soft_rst_req = 1'b0;
    pll_locked   = 1'b1;   // edge 107: new sequence only if state is WAIT_LOCK
    checks++;
    if (phy3 !== 1'b0 || pre3 !== 3'b111 || rdy3 !== 1'b0) begin
      failures++;
      $display("FAIL soft_lockloss: phy=%b pre=%b rdy=%b want 0 111 0", phy3, pre3, rdy3);
    end
    run_to(111);
    checks++;
    if (phy3 !== 1'b0) begin
      failures++;
      $display("FAIL soft_lockloss_phy111: phy=%b want 0", phy3);
    end
    step();
    checks++;
    if (phy3 !== 1'b1) begin
      failures++;
      $display("FAIL soft_lockloss_phy112: phy=%b want 1", phy3);
    end
    run_to(124);
    checks++;
    if (pre3 !== 3'b000 || rdy3 !== 1'b1) begin
      failures++;
      $display("FAIL soft_lockloss_done: pre=%b rdy=%b want 000 1", pre3, rdy3);
    end
  endtask

  task automatic test_sys_reset_mid_release();
    run_to(129);
    soft_rst_req = 1'b1;   // t=130
    step();
    soft_rst_req = 1'b0;
    run_to(145);
    checks++;
    if (pre3 !== 3'b100 || rdy3 !== 1'b0) begin
      failures++;
      $display("FAIL mid_release: pre=%b rdy=%b want 100 0", pre3, rdy3);
    end
    sys_rst_n = 1'b0;      // edge 146
    step();
    sys_rst_n = 1'b1;
    checks++;
    if (phy3 !== 1'b0 || pre3 !== 3'b111 || rdy3 !== 1'b0) begin
      failures++;
      $display("FAIL sysrst_release: phy=%b pre=%b rdy=%b want 0 111 0", phy3, pre3, rdy3);
    end
    pll_locked = 1'b0;     // hold off relock to show the sequence waits
    run_to(150);
    checks++;
    if (phy3 !== 1'b0 || pre3 !== 3'b111 || rdy3 !== 1'b0) begin
      failures++;
      $display("FAIL sysrst_wait: phy=%b pre=%b rdy=%b want 0 111 0", phy3, pre3, rdy3);
    end
    pll_locked = 1'b1;     // t=151
    for (int e = 151; e <= 170; e++) begin
      step();
      checks++;
      if (phy3 !== exp_phy(151, e) || pre3 !== exp_pre(151, e) || rdy3 !== exp_rdy(151, e)) begin
        failures++;
        $display("FAIL after_sysrst edge %0d: phy=%b pre=%b rdy=%b want %b %b %b",
                 e, phy3, pre3, rdy3, exp_phy(151, e), exp_pre(151, e), exp_rdy(151, e));
      end
      checks++;
      if (rdy1 !== (e >= 164) || pre1 !== (e >= 164 ? 1'b0 : 1'b1)) begin
        failures++;
        $display("FAIL after_sysrst_n1 edge %0d: pre=%b rdy=%b want %b %b",
                 e, pre1, rdy1, (e < 164), (e >= 164));
      end
    end
  endtask

  initial begin
    test_reset();
    test_cold_start();
    test_lock_loss();
    test_soft_reset();
    test_soft_with_lock_loss();
    test_sys_reset_mid_release();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/liteeth_rst_seq.md
# liteeth_rst_seq

Power-on and soft-reset sequencer for the LiteEth PHY/MAC clocking section. It drives the external PHY reset pin, waits a settle interval, then releases the active-high asynchronous presets that feed the per-domain preset-flop reset synchronizer chains. Presets are released in a fixed staggered order, so the synchronizers and the MAC domains come out of reset deterministically. It asserts those presets; the synchronizer chains are their receiving end.

## Interface
- `ASSERT_CYCLES`, 256: cycles `phy_rst_n` is held low per sequence; must be ≥1.
- `SETTLE_CYCLES`, 1024: cycles between PHY release and the first domain release; must be ≥1.
- `STAGGER_CYCLES`, 16: spacing between consecutive domain releases; must be ≥1.
- `N_DOMAINS`, 3: number of domain preset outputs; range 1..8.

Ports:
- `sys_clk` in 1: single clock; all logic on its rising edge.
- `sys_rst_n` in 1: reset is synchronous and active-low.
- `pll_locked` in 1: PLL lock indication, already synchronized to `sys_clk`.
- `soft_rst_req` in 1: single-cycle request to re-run the PHY reset sequence.
- `phy_rst_n` out 1: PHY reset pin, active-low, registered.
- `dom_pre` out N_DOMAINS: per-domain preset, active-high, registered; bit 0 is released first.
- `ready` out 1: high when every domain is released, registered.

## Operation
- Values while `sys_rst_n`=0 (sampled): state WAIT_LOCK, `phy_rst_n`=0, `dom_pre`=all 1, `ready`=0, counter=0, release index=0.
- WAIT_LOCK: all outputs hold their reset values. When `pll_locked`=1, go to PHY_RST and clear the counter.
- PHY_RST: `phy_rst_n`=0 for exactly ASSERT_CYCLES cycles, then `phy_rst_n`→1 and go to SETTLE.
- SETTLE: lasts exactly SETTLE_CYCLES cycles, then go to RELEASE with index 0.
- RELEASE:
  - Clear `dom_pre[0]` on entry.
  - Clear `dom_pre[i]` STAGGER_CYCLES after `dom_pre[i-1]`.
  - On the edge that clears `dom_pre[N_DOMAINS-1]`, also set `ready`=1 and go to DONE.
- DONE: outputs stay static.
- Loss of lock: `pll_locked`=0 in any state other than WAIT_LOCK → next edge returns to WAIT_LOCK with every output at its reset value.
- Soft reset: `soft_rst_req`=1 in PHY_RST, SETTLE, RELEASE or DONE with `pll_locked`=1 → next edge:
  - state PHY_RST with the counter restarted.
  - `phy_rst_n`=0, `dom_pre`=all 1, `ready`=0.
- `soft_rst_req` is ignored in WAIT_LOCK.
- Priority: `sys_rst_n` > loss of lock > `soft_rst_req` > normal progress.
- Once cleared, a `dom_pre` bit never re-asserts except through reset, loss of lock or soft reset; in those cases all bits re-assert together.

## Timing
- Take `pll_locked` sampled high at edge t in WAIT_LOCK:
  - `phy_rst_n` stays low through edge t+ASSERT_CYCLES and rises at edge t+1+ASSERT_CYCLES.
  - `dom_pre[i]` falls at edge t+1+ASSERT_CYCLES+SETTLE_CYCLES+i·STAGGER_CYCLES.
  - `ready` rises on the same edge as `dom_pre[N_DOMAINS-1]`.
- Soft reset sampled at edge s gives the same timeline, with t replaced by s.
- Counter width is $clog2(max(ASSERT_CYCLES, SETTLE_CYCLES, STAGGER_CYCLES)+1). The counter saturates and never wraps.
- The release index is $clog2(N_DOMAINS+1) bits wide.
- All outputs are flop outputs, with no combinational path from any input to any output.

## Structure
- Package `liteeth_rst_seq_pkg`:
  - State enum: WAIT_LOCK, PHY_RST, SETTLE, RELEASE, DONE.
  - Helper function for the counter width.
  - Parameter range check constants.
- Sub-module `liteeth_rst_timer`: loadable down-counter with a `load` input, a `value` input and a single-cycle `expired` output. The FSM reloads it with ASSERT_CYCLES, SETTLE_CYCLES or STAGGER_CYCLES on each phase entry.
- Top level holds the FSM, release index and output registers.

## Test plan
All scenarios use ASSERT=4, SETTLE=8, STAGGER=2, N_DOMAINS=3.
- Cold start, lock at edge 10:
  - `phy_rst_n` rises at 15.
  - `dom_pre` changes 111→110 at 23, →100 at 25, →000 at 27.
  - `ready`=1 at 27.
- Lock lost at edge 20 during SETTLE: at 21, `phy_rst_n`=0, `dom_pre`=111, `ready`=0. Relock at 30 gives the full timeline from 30.
- `soft_rst_req` pulse at edge 40 in DONE:
  - At 41, `phy_rst_n`=0, `dom_pre`=111, `ready`=0.
  - `phy_rst_n` rises at 45 and `ready` at 57.
- `soft_rst_req` and lock loss in the same cycle: state goes to WAIT_LOCK, not PHY_RST.
- `sys_rst_n` low for one cycle mid-RELEASE (`dom_pre`=100): next cycle all outputs are at reset values and the sequence waits for lock.
- N_DOMAINS=1: `dom_pre[0]` and `ready` change on the same edge, at t+13.
